// File: rtl/arb4_rr_ctrl.sv
// arb4_rr_ctrl: four-requester bus arbiter with fixed-priority or
// round-robin selection, one-hot registered grants, a hold limit and a
// mandatory idle cycle between consecutive grants.
module arb4_rr_ctrl #(
    parameter int DW       = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic [3:0]    req,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    output logic [3:0]    gnt,
    output logic [DW-1:0] dout,
    output logic          dout_valid
);

    // The counter needs at least one bit, even when the hold limit is disabled.
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [3:0]    gnt_next;
    logic [1:0]    last, last_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    win;
    logic [1:0]    cand;
    logic          found;
    logic          hold_expired;

    // Winner selection: highest index in fixed mode, or a rotating search
    // starting just below the last granted index in round-robin mode.
    always_comb begin
        win   = 2'd0;
        cand  = 2'd0;
        found = 1'b0;
        if (mode) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    win = 2'(i);
                end
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                cand = last - 2'(k);
                if (!found && req[cand]) begin
                    win   = cand;
                    found = 1'b1;
                end
            end
        end
    end

    // The hold limit only applies when it is non-zero.
    assign hold_expired = (MAX_HOLD != 0) && (cnt == HOLD_LIM);

    // Next-state logic: arbitrate from IDLE, hold or release from GRANT.
    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        last_next  = last;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                gnt_next = 4'b0000;
                if (|req) begin
                    gnt_next   = 4'b0001 << win;
                    cnt_next   = CW'(1);
                    last_next  = win;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (!req[last] || hold_expired) begin
                    gnt_next   = 4'b0000;
                    state_next = IDLE;
                end else if (cnt != {CW{1'b1}}) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                gnt_next   = 4'b0000;
                state_next = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset overriding any grant in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            last  <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            last  <= last_next;
            cnt   <= cnt_next;
        end
    end

    // Output bus follows the registered grant combinationally.
    always_comb begin
        case (gnt)
            4'b1000: dout = a;
            4'b0100: dout = b;
            4'b0010: dout = c;
            4'b0001: dout = d;
            default: dout = '0;
        endcase
    end

    assign dout_valid = |gnt;

endmodule
